uart_tx: RTL and testbench

//   8N1 UART transmitter: serialises bytes onto tx, LSB first, at CLKDIV clocks per bit.

---
 rtl/uart_tx.sv | 169 ++++++++++++++++
 tb/tb_uart_tx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register for gap-free back-to-back frames.
// Optional feature: define UARTTX_PARITY_EN for 8E1 frames (even parity bit before stop).
module uart_tx #(
    parameter int unsigned CLKDIV = 100000000 / 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic [1:0] leds
);

    localparam int unsigned BCW = 16;
    localparam int unsigned NCW = 3;
    localparam logic [BCW-1:0] BIT_END = BCW'(CLKDIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UARTTX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e         state_q, state_d;
    logic [7:0]     hold_q, hold_d;
    logic           hold_full_q, hold_full_d;
    logic [7:0]     shift_q, shift_d;
    logic [BCW-1:0] bitclk_q, bitclk_d;
    logic [NCW-1:0] bitcnt_q, bitcnt_d;
    logic           tx_q, tx_d;
`ifdef UARTTX_PARITY_EN
    logic           parity_q, parity_d;
`endif
    logic           accept_c;
    logic           end_bit_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            shift_q     <= 8'h00;
            bitclk_q    <= '0;
            bitcnt_q    <= '0;
            tx_q        <= 1'b1;
`ifdef UARTTX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bitclk_q    <= bitclk_d;
            bitcnt_q    <= bitcnt_d;
            tx_q        <= tx_d;
`ifdef UARTTX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    // Next-state, bit timing and holding-register handshake
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bitclk_d    = bitclk_q;
        bitcnt_d    = bitcnt_q;
`ifdef UARTTX_PARITY_EN
        parity_d    = parity_q;
`endif
        accept_c    = valid & ~hold_full_q;
        end_bit_c   = (bitclk_q == BIT_END);

        if (state_q != S_IDLE) begin
            bitclk_d = end_bit_c ? '0 : bitclk_q + BCW'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                bitclk_d = '0;
                if (hold_full_q) begin
                    state_d     = S_START;
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
`ifdef UARTTX_PARITY_EN
                    parity_d    = ^hold_q;
`endif
                end
            end
            S_START: begin
                if (end_bit_c) begin
                    state_d  = S_DATA;
                    bitcnt_d = '0;
                end
            end
            S_DATA: begin
                if (end_bit_c) begin
                    shift_d  = {1'b0, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + NCW'(1);
                    if (bitcnt_q == NCW'(7)) begin
`ifdef UARTTX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UARTTX_PARITY_EN
            S_PARITY: begin
                if (end_bit_c) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (end_bit_c) begin
                    if (hold_full_q) begin
                        state_d     = S_START;
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
`ifdef UARTTX_PARITY_EN
                        parity_d    = ^hold_q;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Accept only happens with the holding register empty, so it never races a transfer
        if (accept_c) begin
            hold_d      = d;
            hold_full_d = 1'b1;
        end
    end

    // Line level is a registered decode of the current state
    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            S_IDLE:   tx_d = 1'b1;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
`ifdef UARTTX_PARITY_EN
            S_PARITY: tx_d = parity_q;
`endif
            S_STOP:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    assign ready = ~hold_full_q;
    assign busy  = (state_q != S_IDLE);
    assign leds  = {hold_full_q, busy};
    assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed, table-driven bench for uart_tx at CLKDIV=4 with a serial-line receiver model.
module tb_uart_tx;

    localparam int unsigned CLKDIV = 4;
`ifdef UARTTX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d;
    logic       valid;
    logic       ready;
    logic       tx;
    logic       busy;
    logic [1:0] leds;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0]  d;
        logic [10:0] frame;
    } vec_t;

    vec_t vecs[3];

    uart_tx #(.CLKDIV(CLKDIV)) dut (
        .clk   (clk),
        .rst   (rst),
        .d     (d),
        .valid (valid),
        .ready (ready),
        .tx    (tx),
        .busy  (busy),
        .leds  (leds)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Present b at a negedge and hold valid until the edge that accepts it
    task automatic offer(input logic [7:0] b);
        int n;
        n = 0;
        d     = b;
        valid = 1'b1;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("offer_timeout", 32'd0, 32'd1);
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Compare tx every cycle against a bit pattern, bit 0 first, CLKDIV cycles per bit
    task automatic check_frames(input logic [21:0] bits, input int nbits);
        for (int k = 0; k < nbits * int'(CLKDIV); k++) begin
            chk($sformatf("tx_bit%0d_cyc%0d", k / int'(CLKDIV), k), 32'(tx), 32'(bits[k / int'(CLKDIV)]));
            if (k == nbits * int'(CLKDIV) - 2) chk("busy_late_in_frame", 32'(busy), 32'd1);
            @(negedge clk);
        end
        chk("tx_idle_after", 32'(tx), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        chk("ready_after", 32'(ready), 32'd1);
    endtask

    // Receiver model: mid-bit sampling of the serial line
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                repeat (CLKDIV / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CLKDIV) @(negedge clk);
                    b[i] = tx;
                end
`ifdef UARTTX_PARITY_EN
                repeat (CLKDIV) @(negedge clk);
                chk("rx_parity", 32'(tx), 32'(^b));
`endif
                repeat (CLKDIV) @(negedge clk);
                chk("rx_stop", 32'(tx), 32'd1);
                rx_q.push_back(b);
            end
        end
    end

    initial begin
        logic [7:0] bp[3];
        int acc_t[3];
        int t;
        int idx;
        int n;
        logic stayed_high;
        logic [10:0] fa5, f3c;

`ifdef UARTTX_PARITY_EN
        vecs[0] = '{d: 8'h55, frame: 11'h4AA};
        vecs[1] = '{d: 8'h07, frame: 11'h60E};
        vecs[2] = '{d: 8'h03, frame: 11'h406};
        fa5 = 11'h54A;
        f3c = 11'h478;
`else
        vecs[0] = '{d: 8'h55, frame: 11'h2AA};
        vecs[1] = '{d: 8'h07, frame: 11'h20E};
        vecs[2] = '{d: 8'h03, frame: 11'h206};
        fa5 = 11'h34A;
        f3c = 11'h278;
`endif

        // Reset
        rst   = 1'b1;
        d     = 8'h00;
        valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_leds", 32'(leds), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_tx", 32'(tx), 32'd1);

        // Single bytes from the table
        foreach (vecs[i]) begin
            exp_q.push_back(vecs[i].d);
            offer(vecs[i].d);
            chk("tx_high_accept_plus0", 32'(tx), 32'd1);
            @(negedge clk);
            chk("tx_high_accept_plus1", 32'(tx), 32'd1);
            chk("busy_rises", 32'(busy), 32'd1);
            @(negedge clk);
            chk("leds_single", 32'(leds), 32'b01);
            check_frames(22'(vecs[i].frame), NB);
            repeat (3) @(negedge clk);
        end

        // Back-to-back frames, no idle gap
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        offer(8'hA5);
        offer(8'h3C);
        chk("leds_b2b", 32'(leds), 32'b11);
        check_frames((22'(f3c) << NB) | 22'(fa5), 2 * NB);
        repeat (3) @(negedge clk);

        // Backpressure with valid held high
        bp[0] = 8'h11;
        bp[1] = 8'h22;
        bp[2] = 8'h33;
        t = 0;
        idx = 0;
        d = bp[0];
        valid = 1'b1;
        while (idx < 3 && t < 400) begin
            if (ready) begin
                acc_t[idx] = t;
                exp_q.push_back(bp[idx]);
                idx++;
            end
            @(negedge clk);
            t++;
            if (idx < 3) d = bp[idx];
            else valid = 1'b0;
        end
        valid = 1'b0;
        chk("bp_all_accepted", 32'(idx), 32'd3);
        chk("bp_second_gap", 32'(acc_t[1] - acc_t[0]), 32'd2);
        chk("bp_third_gap", 32'(acc_t[2] - acc_t[0]), 32'(NB * int'(CLKDIV) + 2));
        n = 0;
        while (!(ready && !busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("bp_drain", 32'(n < 400), 32'd1);
        repeat (6) @(negedge clk);

        // Reset mid-frame with a byte waiting in holding
        exp_q.push_back(8'hFF);
        offer(8'hFF);
        offer(8'h00);
        repeat (10) @(negedge clk);
        chk("abort_leds_before", 32'(leds), 32'b11);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_leds", 32'(leds), 32'd0);
        rst = 1'b0;
        stayed_high = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) stayed_high = 1'b0;
        end
        chk("abort_no_frame", 32'(stayed_high), 32'd1);

        // Receiver-side ordering
        chk("rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            chk($sformatf("rx_byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
